i2c_temp_reader: RTL

Periodic I2C master that polls an ADT7420-class temperature sensor and produces the 8-bit integer Celsius value consumed by the seven-segment display driver. Sits directly upstream of the display: its `temp_data` output wires straight to the display's `temp_data` input. Each poll issues one read transaction (START, address+R, two data bytes, STOP), converts the 16-bit register to whole degrees, and updates `temp_data` atomically.

---
 rtl/i2c_temp_pkg.sv | 23 ++
 rtl/i2c_temp_reader_qtr_tick.sv | 33 +++
 rtl/i2c_temp_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/i2c_temp_pkg.sv
// Shared types and constants for the ADT7420 temperature poller and its
// quarter-bit timing generator.
package i2c_temp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    RD_MSB,
    M_ACK,
    RD_LSB,
    M_NACK,
    STOP
  } i2c_state_t;

  localparam logic       I2C_RD       = 1'b1;
  localparam logic [6:0] ADT7420_ADDR = 7'h4B;

  // Index of the quarter within the current I2C bit (q0..q3)
  typedef logic [1:0] qphase_t;

endpackage

// File: rtl/i2c_temp_reader_qtr_tick.sv
// Quarter-bit timebase: one-cycle strobe every QTR clocks plus the 2-bit
// phase within the bit; held at zero whenever the bus is idle.
module i2c_qtr_tick
  import i2c_temp_pkg::*;
#(
  parameter int QTR = 62
) (
  input  logic    clk_50MHz,
  input  logic    reset,
  input  logic    en,
  output logic    tick,
  output qphase_t phase
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(QTR - 1));

  always_ff @(posedge clk_50MHz) begin
    if (reset || !en) begin
      cnt   <= '0;
      phase <= '0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_temp_reader.sv
// Periodic I2C read of an ADT7420-class sensor, producing whole degrees C.
// Define I2C_TEMP_ACK_CHECK_EN to abort on an address NACK and raise sticky err.
module i2c_temp_reader
  import i2c_temp_pkg::*;
#(
  parameter int         CLK_HZ      = 50_000_000,
  parameter int         SCL_HZ      = 200_000,
  parameter logic [6:0] DEV_ADDR    = ADT7420_ADDR,
  parameter int         POLL_CYCLES = 12_500_000
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  output wire        scl,
  inout  wire        sda,
  output logic [7:0] temp_data,
  output logic       temp_valid,
  output logic       busy,
  output logic       err
);

  localparam int QTR = CLK_HZ / (4 * SCL_HZ);
  localparam int PW  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  i2c_state_t    state, state_nxt;
  qphase_t       phase;
  logic [PW-1:0] poll_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg, msb_q;
  logic          poll_wrap, tick, bit_end, sample_pt;
  logic          scl_low, sda_low, addr_nack;
  logic          sda_s1, sda_s2;

  // Negative readings clamp to zero; otherwise keep integer bits only
  function automatic logic [7:0] sat_celsius(input logic [7:0] msb, input logic lsb_b7);
    return msb[7] ? 8'd0 : {msb[6:0], lsb_b7};
  endfunction

  assign busy      = (state != IDLE);
  assign poll_wrap = (poll_cnt == PW'(POLL_CYCLES - 1));
  assign bit_end   = tick && (phase == 2'd3);
  assign sample_pt = tick && (phase == 2'd2);
  assign scl       = scl_low ? 1'b0 : 1'bz;
  assign sda       = sda_low ? 1'b0 : 1'bz;

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .en       (busy),
    .tick     (tick),
    .phase    (phase)
  );

  // Free-running so the poll period does not depend on transaction length
  always_ff @(posedge clk_50MHz) begin
    if (reset || poll_wrap) poll_cnt <= '0;
    else                    poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk_50MHz) begin
    sda_s1 <= sda;
    sda_s2 <= sda_s1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_low   = 1'b0;
    sda_low   = 1'b0;
    case (state)
      IDLE:  if (poll_wrap) state_nxt = START;
      START: begin
        sda_low = phase[1];
        if (bit_end) state_nxt = ADDR;
      end
      ADDR: begin
        scl_low = !phase[1];
        sda_low = !shreg[7];
        if (bit_end && bit_idx == 3'd7) state_nxt = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_low = !phase[1];
        if (bit_end) state_nxt = addr_nack ? STOP : RD_MSB;
      end
      RD_MSB: begin
        scl_low = !phase[1];
        if (bit_end && bit_idx == 3'd7) state_nxt = M_ACK;
      end
      M_ACK: begin
        scl_low = !phase[1];
        sda_low = 1'b1;
        if (bit_end) state_nxt = RD_LSB;
      end
      RD_LSB: begin
        scl_low = !phase[1];
        if (bit_end && bit_idx == 3'd7) state_nxt = M_NACK;
      end
      M_NACK: begin
        scl_low = !phase[1];
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        scl_low = !phase[1];
        sda_low = (phase != 2'd3);
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset || state == IDLE)
      bit_idx <= '0;
    else if (bit_end && (state == ADDR || state == RD_MSB || state == RD_LSB))
      bit_idx <= bit_idx + 3'd1;
  end

  // Shared shifter: address out MSB first, then each data byte in
  always_ff @(posedge clk_50MHz) begin
    if (state == IDLE)
      shreg <= {DEV_ADDR, I2C_RD};
    else if (state == ADDR && bit_end)
      shreg <= {shreg[6:0], 1'b0};
    else if ((state == RD_MSB || state == RD_LSB) && sample_pt)
      shreg <= {shreg[6:0], sda_s2};
    if (state == M_ACK && bit_end)
      msb_q <= shreg;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      temp_data  <= '0;
      temp_valid <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (state == STOP && bit_end && !addr_nack) begin
        temp_data  <= sat_celsius(msb_q, shreg[7]);
        temp_valid <= 1'b1;
      end
    end
  end

`ifdef I2C_TEMP_ACK_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      addr_nack <= 1'b0;
      err_q     <= 1'b0;
    end else if (state == IDLE) begin
      addr_nack <= 1'b0;
    end else if (state == ADDR_ACK && sample_pt && sda_s2) begin
      addr_nack <= 1'b1;
      err_q     <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign addr_nack = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
